// File: rtl/collision_ctrl_pkg.sv
// Shared board geometry and collision-check state encoding.
package collision_ctrl_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_DONE
  } coll_state_t;

  // Row-major board address, truncated to the RAM width.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] y, input logic [4:0] x);
    int a;
    a = int'(y) * BOARD_W + int'(x);
    return a[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/collision_ctrl_if.sv
// Handshake between the collision controller, its datapath and the board RAM.
interface collision_ctrl_if;
  import collision_ctrl_pkg::*;

  logic              start;
  logic              y_eQ_zero;
  logic              in_id_eQ_zero;
  logic              pos_x_eQ_limit;
  logic [4:0]        pos_y;
  logic [4:0]        pos_x;
  logic              init_regs;
  logic              incr_x;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              collide;

  modport master (
    output start, y_eQ_zero, in_id_eQ_zero, pos_x_eQ_limit, pos_y, pos_x,
    input  init_regs, incr_x, rd_en, rd_addr, busy, done, collide
  );

  modport slave (
    input  start, y_eQ_zero, in_id_eQ_zero, pos_x_eQ_limit, pos_y, pos_x,
    output init_regs, incr_x, rd_en, rd_addr, busy, done, collide
  );

endinterface

// File: rtl/collision_ctrl.sv
// Downward-collision check FSM: walks the cells under the piece, reading the
// board RAM for each, and reports collide/clear with a one-cycle done.
module collision_ctrl
  import collision_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  collision_ctrl_if.slave   bus
);

  localparam int CNT_W = 2;

  coll_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             collide_q, collide_d;
  logic             wall;

  // A column past the right edge counts as a hit without touching the RAM.
  assign wall = (int'(bus.pos_x) >= BOARD_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      collide_q <= collide_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    collide_d = collide_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.y_eQ_zero) begin
            collide_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            collide_d = 1'b0;
            state_d   = S_INIT;
          end
        end
      end
      S_INIT: state_d = S_READ;
      S_READ: begin
        if (wall) begin
          collide_d = 1'b1;
          state_d   = S_DONE;
        end else if (RD_LAT == 1) begin
          state_d = S_CHECK;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!bus.in_id_eQ_zero) begin
          collide_d = 1'b1;
          state_d   = S_DONE;
        end else if (bus.pos_x_eQ_limit) begin
          collide_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.init_regs = (state_q == S_INIT);
    bus.incr_x    = (state_q == S_CHECK) && bus.in_id_eQ_zero && !bus.pos_x_eQ_limit;
    bus.rd_en     = (state_q == S_READ) && !wall;
    bus.rd_addr   = bus.rd_en ? cell_addr(bus.pos_y, bus.pos_x) : '0;
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.collide   = collide_q;
  end

endmodule

// File: tb/tb_collision_ctrl.sv
// Scoreboard bench: two controllers (RD_LAT 1 and 3) with behavioural datapath and board RAM.
`timescale 1ns/1ps
module tb_collision_ctrl;
  import collision_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_ctrl_if b1();
  collision_ctrl_if b3();

  collision_ctrl #(.RD_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  collision_ctrl #(.RD_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b3));

  typedef struct { bit collide; int k; int s; } exp_t;
  exp_t exp_q[2][$];
  int   addr_q[2][$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] x_v[2], y_v[2];
  int         id_v[2];
  logic [2:0] board[256];

  logic              init_w[2], incr_w[2], rden_w[2], busy_w[2], done_w[2], col_w[2];
  logic [ADDR_W-1:0] addr_w[2];
  assign init_w[0] = b1.init_regs; assign init_w[1] = b3.init_regs;
  assign incr_w[0] = b1.incr_x;    assign incr_w[1] = b3.incr_x;
  assign rden_w[0] = b1.rd_en;     assign rden_w[1] = b3.rd_en;
  assign addr_w[0] = b1.rd_addr;   assign addr_w[1] = b3.rd_addr;
  assign busy_w[0] = b1.busy;      assign busy_w[1] = b3.busy;
  assign done_w[0] = b1.done;      assign done_w[1] = b3.done;
  assign col_w[0]  = b1.collide;   assign col_w[1]  = b3.collide;

  function automatic int wid(input int id);
    if (id == 4) return 4;
    if (id == 2) return 2;
    return 3;
  endfunction

  // Behavioural collision_data: column/row/limit registers.
  logic [4:0] px[2], py[2], lim[2];
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        px[i] <= '0; py[i] <= '0; lim[i] <= '0;
      end else if (init_w[i]) begin
        px[i]  <= x_v[i];
        py[i]  <= y_v[i] - 5'd1;
        lim[i] <= x_v[i] + 5'(wid(id_v[i]) - 1);
      end else if (incr_w[i]) begin
        px[i] <= px[i] + 5'd1;
      end
    end
  end

  // Board RAM read pipeline; tap picks the instance's latency.
  logic [2:0] pipe[2][3];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= rden_w[i] ? board[addr_w[i]] : 3'd0;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end

  assign b1.pos_x = px[0]; assign b1.pos_y = py[0];
  assign b3.pos_x = px[1]; assign b3.pos_y = py[1];
  assign b1.y_eQ_zero = (y_v[0] == 5'd0);
  assign b3.y_eQ_zero = (y_v[1] == 5'd0);
  assign b1.pos_x_eQ_limit = (px[0] == lim[0]);
  assign b3.pos_x_eQ_limit = (px[1] == lim[1]);
  assign b1.in_id_eQ_zero = (pipe[0][0] == 3'd0);
  assign b3.in_id_eQ_zero = (pipe[1][2] == 3'd0);

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: compares every read address and every done pulse against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (rden_w[i]) begin
          if (addr_q[i].size() == 0) chk($sformatf("unexpected_rd%0d", i), int'(addr_w[i]), -1);
          else chk($sformatf("rd_addr%0d", i), int'(addr_w[i]), addr_q[i].pop_front());
        end
        if (done_w[i]) begin
          if (exp_q[i].size() == 0) chk($sformatf("unexpected_done%0d", i), 1, 0);
          else begin
            exp_t e;
            e = exp_q[i].pop_front();
            chk($sformatf("done_cycle%0d", i), cyc - e.s, e.k);
            chk($sformatf("collide%0d", i), int'(col_w[i]), int'(e.collide));
          end
        end
      end
    end
  end

  task automatic set_start(input int i, input logic v);
    if (i == 0) b1.start = v; else b3.start = v;
  endtask

  task automatic push_row(input int i, input int y, input int x0, input int n);
    for (int c = 0; c < n; c++) addr_q[i].push_back((y - 1) * BOARD_W + x0 + c);
  endtask

  task automatic start_chk(input int i, input int x, input int y, input int id,
                           input bit col, input int k, input bit push_done, output int s);
    exp_t e;
    @(negedge clk);
    x_v[i] = 5'(x); y_v[i] = 5'(y); id_v[i] = id;
    set_start(i, 1'b1);
    s = cyc;
    if (push_done) begin
      e.collide = col; e.k = k; e.s = s;
      exp_q[i].push_back(e);
    end
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while ((exp_q[i].size() != 0 || busy_w[i]) && t < 100) begin
      @(negedge clk); t++;
    end
    if (t >= 100) chk($sformatf("timeout%0d", i), t, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input int i);
    chk($sformatf("rst_init%0d", i),  int'(init_w[i]), 0);
    chk($sformatf("rst_incr%0d", i),  int'(incr_w[i]), 0);
    chk($sformatf("rst_rden%0d", i),  int'(rden_w[i]), 0);
    chk($sformatf("rst_addr%0d", i),  int'(addr_w[i]), 0);
    chk($sformatf("rst_busy%0d", i),  int'(busy_w[i]), 0);
    chk($sformatf("rst_done%0d", i),  int'(done_w[i]), 0);
    chk($sformatf("rst_col%0d", i),   int'(col_w[i]), 0);
  endtask

  initial begin
    int s;
    for (int a = 0; a < 256; a++) board[a] = 3'd0;
    for (int i = 0; i < 2; i++) begin x_v[i] = '0; y_v[i] = 5'd1; id_v[i] = 1; end
    b1.start = 1'b0; b3.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);
    chk("rst_state", int'(u1.state_q), int'(S_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Floor on the latency-1 instance, so collide is 1 before the reset test.
    start_chk(0, 4, 0, 4, 1'b1, 1, 1'b1, s);
    wait_idle(0);

    // Reset during S_CHECK of the first cell: abort, no done.
    addr_q[0].push_back(93);
    start_chk(0, 3, 10, 4, 1'b0, 0, 1'b0, s);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_state", int'(u1.state_q), int'(S_CHECK));
    reset = 1'b1;
    #1;
    chk_reset_outs(0);
    chk("abort_state", int'(u1.state_q), int'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rd_left", addr_q[0].size(), 0);
    repeat (3) @(negedge clk);

    // Clear row with an ignored second start mid-check.
    push_row(0, 10, 3, 4);
    start_chk(0, 3, 10, 4, 1'b0, 10, 1'b1, s);
    @(negedge clk);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    wait_idle(0);

    // Hit at (5,9): third cell.
    board[95] = 3'd3;
    push_row(0, 10, 3, 3);
    start_chk(0, 3, 10, 4, 1'b1, 8, 1'b1, s);
    wait_idle(0);
    for (int c = 0; c < 4; c++) begin
      chk("hold_col1", int'(col_w[0]), 1);
      @(negedge clk);
    end
    board[95] = 3'd0;

    // Right wall: columns 8,9 read, column 10 is a wall hit.
    push_row(0, 10, 8, 2);
    start_chk(0, 8, 10, 4, 1'b1, 7, 1'b1, s);
    chk("col_cleared_on_start", int'(col_w[0]), 0);
    wait_idle(0);

    // Latency 3, two-wide piece on an empty row.
    push_row(1, 5, 0, 2);
    start_chk(1, 0, 5, 2, 1'b0, 10, 1'b1, s);
    wait_idle(1);
    for (int c = 0; c < 3; c++) begin
      chk("hold_col0", int'(col_w[1]), 0);
      @(negedge clk);
    end
    start_chk(1, 0, 0, 2, 1'b1, 1, 1'b1, s);
    wait_idle(1);

    chk("left_done0", exp_q[0].size(), 0);
    chk("left_done1", exp_q[1].size(), 0);
    chk("left_rd0", addr_q[0].size(), 0);
    chk("left_rd1", addr_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
